// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared types and 7-segment pattern constants for the
//                two-digit display sink (active-high, bit0=a .. bit6=g).
//  Revision    : 1.0  initial release
// ============================================================================
package seg_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  localparam seg7_t SEG_0     = 7'h3F;
  localparam seg7_t SEG_1     = 7'h06;
  localparam seg7_t SEG_2     = 7'h5B;
  localparam seg7_t SEG_3     = 7'h4F;
  localparam seg7_t SEG_4     = 7'h66;
  localparam seg7_t SEG_5     = 7'h6D;
  localparam seg7_t SEG_6     = 7'h7D;
  localparam seg7_t SEG_7     = 7'h07;
  localparam seg7_t SEG_8     = 7'h7F;
  localparam seg7_t SEG_9     = 7'h6F;

  // All segments off (active-high); inverted onto the cathodes gives 7'h7F.
  localparam seg7_t SEG_BLANK = 7'h00;

endpackage
`default_nettype wire

// File: rtl/seg_display_sink_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_sink_if
//  Description : Valid/ready word interface carrying two 7-segment patterns
//                ([0] = ones, [1] = tens).
//  Revision    : 1.0  initial release
// ============================================================================
interface seg_display_sink_if;
  import seg_pkg::*;

  logic        s_valid;
  logic        s_ready;
  seg7_t [1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational 7-segment pattern to BCD digit decoder.
//                Anything other than the ten standard glyphs is flagged
//                invalid and decodes to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
  import seg_pkg::*;
(
  input  seg7_t      pattern,
  output logic [3:0] digit,
  output logic       valid
);

  // Map each standard glyph to its digit; everything else is invalid.
  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_display_sink.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_sink
//  Description : Accepts a two-digit 7-segment word over valid/ready, scans
//                it onto a multiplexed common-anode display and reports the
//                binary value. A new word is only accepted after MIN_FRAMES
//                complete scan frames of the current one.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_display_sink
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int MIN_FRAMES  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  seg_display_sink_if.slave  s_if,
  output logic [1:0]         an,
  output logic [6:0]         seg,
  output logic [6:0]         value,
  output logic               err
);

  localparam int REF_W   = $clog2(REFRESH_DIV);
  localparam int FRAME_W = $clog2(MIN_FRAMES + 1);

  localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_SAT  = FRAME_W'(MIN_FRAMES);

  state_t               state;
  state_t               state_next;
  seg7_t [1:0]          latched;
  logic [REF_W-1:0]     refresh_cnt;
  logic                 digit_sel;
  logic [FRAME_W-1:0]   frame_cnt;
  logic                 load_pending;

  logic                 frames_done;
  logic                 ready;
  logic                 xfer;

  logic [3:0]           ones_digit;
  logic [3:0]           tens_digit;
  logic                 ones_ok;
  logic                 tens_ok;
  logic [6:0]           ones_val;
  logic [6:0]           tens_val;
  logic [6:0]           value_next;

  // Ready is a pure function of registered state so it never depends on s_valid.
  assign frames_done = (frame_cnt == FRAME_SAT);
  assign ready       = (state == ST_IDLE) || frames_done;
  assign xfer        = s_if.s_valid && ready;
  assign s_if.s_ready = ready;

  seg7_decode u_dec_ones (
    .pattern (latched[0]),
    .digit   (ones_digit),
    .valid   (ones_ok)
  );

  seg7_decode u_dec_tens (
    .pattern (latched[1]),
    .digit   (tens_digit),
    .valid   (tens_ok)
  );

  // Invalid glyphs contribute 0; tens*10 built as (x<<3)+(x<<1).
  assign ones_val   = ones_ok ? {3'b000, ones_digit} : 7'd0;
  assign tens_val   = tens_ok ? {3'b000, tens_digit} : 7'd0;
  assign value_next = (tens_val << 3) + (tens_val << 1) + ones_val;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and display drive; SHOW is only left through reset.
  always_comb begin
    state_next = state;
    an         = 2'b11;
    seg        = ~SEG_BLANK;
    if (xfer) begin
      state_next = ST_SHOW;
    end
    if (state == ST_SHOW) begin
      an  = ~(2'b01 << digit_sel);
      seg = ~latched[digit_sel];
    end
  end

  // Word latch plus refresh / digit / frame counters; a transfer restarts all.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      latched     <= '0;
      refresh_cnt <= '0;
      digit_sel   <= 1'b0;
      frame_cnt   <= '0;
    end else if (xfer) begin
      latched     <= s_if.s_data;
      refresh_cnt <= '0;
      digit_sel   <= 1'b0;
      frame_cnt   <= '0;
    end else if (state == ST_SHOW) begin
      if (refresh_cnt == REF_LAST) begin
        refresh_cnt <= '0;
        digit_sel   <= ~digit_sel;
        if (digit_sel && !frames_done) begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  // Decode result registered the cycle after the word is latched, then held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_pending <= 1'b0;
      value        <= 7'd0;
      err          <= 1'b0;
    end else begin
      load_pending <= xfer;
      if (load_pending) begin
        value <= value_next;
        err   <= ~(ones_ok & tens_ok);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/seg_display_sink.md
SEG_DISPLAY_SINK -- requirements
Module: seg_display_sink

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clocks each digit is driven per scan slot; legal range >= 2.
REQ-002 Parameter MIN_FRAMES, default 4: complete two-digit scan frames shown before a new word is accepted; legal range >= 1.
REQ-003 Port clk, input, 1: single clock; all flops on rising edge.
REQ-004 Port rstn, input, 1: asynchronous, active-low reset.
REQ-005 Port s_valid, input, 1: upstream word valid.
REQ-006 Port s_ready, output, 1: block can accept a word.
REQ-007 Port s_data, input, [1:0][6:0]: 7-segment patterns, active-high. [0] is ones and [1] is tens; bit0=a .. bit6=g ("0"=7'b0111111).
REQ-008 Port an, output, 2: digit enables, active-low; an[0] selects the ones digit.
REQ-009 Port seg, output, 7: cathodes, active-low (bitwise inverse of the selected pattern).
REQ-010 Port value, output, 7: binary decode, tens*10+ones, range 0..99.
REQ-011 Port err, output, 1: latched word contained a non-digit pattern.

Function
REQ-012 The block SHALL have states IDLE (nothing to show) and SHOW (displaying a latched word).
REQ-013 Transfer SHALL occur on a rising edge with s_valid && s_ready.
  - Both patterns are latched that edge.
  - State becomes SHOW.
  - Refresh counter, digit select and frame counter clear to 0.
REQ-014 In IDLE:
  - s_ready=1, an=2'b11, seg=7'h7F.
  - value and err hold their last values.
REQ-015 In SHOW, the refresh counter SHALL count 0..REFRESH_DIV-1. On wrap, the digit select toggles 0->1->0.
  - A 1->0 toggle completes one frame.
  - The frame counter saturates at MIN_FRAMES.
REQ-016 In SHOW, an SHALL be ~(2'b01 << digit select), and seg SHALL be ~latched[digit select].
REQ-017 In SHOW, s_ready SHALL equal (frame counter == MIN_FRAMES).
  - SHOW persists until the next transfer.
  - There is no return to IDLE except by reset.
REQ-018 s_ready SHALL depend only on registered state, never combinationally on s_valid.
REQ-019 Decode SHALL map each latched pattern to 0..9 using the ten standard patterns.
  - Any other pattern is invalid and counts as 0 in value.
  - value and err are registered one cycle after transfer and are stable through SHOW.
REQ-020 err SHALL be 1 if either latched pattern is invalid; otherwise 0.
REQ-021 A transfer arriving while s_ready=0 SHALL be ignored; s_valid may stay high until accepted.
REQ-022 A transfer on the same edge as frame saturation SHALL restart counting from 0 (the transfer wins).

Reset
REQ-023 On rstn low, the block SHALL immediately enter:
  - IDLE;
  - all counters 0;
  - latched patterns 0;
  - s_ready=1, an=2'b11, seg=7'h7F, value=0, err=0.
REQ-024 Reset mid-SHOW SHALL discard the latched word; after release, the block SHALL accept a new word on the first edge with s_valid high.

Structure
REQ-025 A shared package seg_pkg SHALL hold:
  - the ten 7-bit digit pattern constants;
  - the blank constant;
  - a state enum typedef;
  - a seg7_t typedef (logic [6:0]).
REQ-026 A combinational sub-module seg7_decode (pattern -> 4-bit digit plus valid flag) SHALL be instantiated twice.
REQ-027 Counter widths SHALL be $clog2 of their parameter range.

Verification (bench uses REFRESH_DIV=4, MIN_FRAMES=2)
REQ-028 Reset release, s_valid=0 -> an=11, seg=7F and s_ready=1 indefinitely.
REQ-029 Send {tens=7'b1011011, ones=7'b1001111} -> value=23, err=0, an alternating 10/01 every 4 clocks, and seg=~pattern per slot; s_ready low for 16 clocks, then high.
REQ-030 Hold s_valid high with a second word {0x06,0x3F} -> accepted exactly at the cycle s_ready rises; value=10.
REQ-031 Send {7'h00, 7'b1101111} -> err=1, value=9.
REQ-032 Assert rstn low mid-SHOW (digit 1 active) -> next cycle an=11, value=0, s_ready=1; a word sent right after release is accepted.
REQ-033 s_valid pulsed while s_ready=0 -> no change to value, an sequence or frame count.
